// File: rtl/vector_alu_pkg.sv
// Shared types, encodings and helpers for the vector integer lane ALU blocks.
package vector_alu_pkg;

   localparam int unsigned TAG_W     = 8;
   localparam int unsigned SEW_W     = 2;
   // Upper bound on datapath width supported by the mask helper.
   localparam int unsigned MAX_WIDTH = 512;

   typedef enum logic [SEW_W-1:0] {
      SEW_8  = 2'b00,
      SEW_16 = 2'b01,
      SEW_32 = 2'b10,
      SEW_64 = 2'b11
   } sew_e;

   // Side-band control that travels with every pipeline stage.
   typedef struct packed {
      sew_e             sew;
      logic             sub;
      logic [TAG_W-1:0] tag;
   } ctl_t;

   // Element width in bits, clamped to the datapath width.
   function automatic int unsigned elem_bits(sew_e sew, int unsigned width);
      int unsigned eb;
      eb = 32'd8 << sew;
      if (eb > width) begin
         eb = width;
      end
      return eb;
   endfunction

   // One bit set at the LSB position of every element in a width-bit slice.
   function automatic logic [MAX_WIDTH-1:0] boundary_mask(sew_e sew, int unsigned width);
      logic [MAX_WIDTH-1:0] m;
      int unsigned          eb;
      m  = '0;
      eb = elem_bits(sew, width);
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
         if ((i < width) && ((i & (eb - 32'd1)) == 32'd0)) begin
            m[i] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/prefix_gp_cell.sv
// Kogge-Stone black cell: merges a (g,p) pair with the pair 2^k bits below it.
module prefix_gp_cell (
   input  logic g_hi_i,
   input  logic p_hi_i,
   input  logic g_lo_i,
   input  logic p_lo_i,
   output logic g_o,
   output logic p_o
);

   assign g_o = g_hi_i | (p_hi_i & g_lo_i);
   assign p_o = p_hi_i & p_lo_i;

endmodule

// File: rtl/vector_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with per-element carry kill and
// a single global advance for back-pressure.
module vector_prefix_adder
   import vector_alu_pkg::*;
#(
   parameter int unsigned WIDTH       = 64,
   parameter int unsigned PIPE_STAGES = 2,
   parameter int unsigned LOG2W       = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [1:0]           in_sew,
   input  logic                 in_sub,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_sum,
   output logic [WIDTH/8-1:0]   out_cout,
   output logic [TAG_W-1:0]     out_tag
);

   localparam int unsigned NBND  = LOG2W + 1;
   localparam int unsigned NBYTE = WIDTH / 8;

   // Boundary b sits after prefix level b-1; true when a pipeline register lives there.
   function automatic logic reg_at(int unsigned bnd);
      logic hit;
      hit = 1'b0;
      for (int unsigned r = 1; r < PIPE_STAGES; r++) begin
         if ((r * LOG2W + PIPE_STAGES - 1) / PIPE_STAGES == bnd) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

   // Per-boundary state: _d enters the boundary, _q leaves it (registered or wired).
   logic [WIDTH-1:0] bnd_g_d   [NBND];
   logic [WIDTH-1:0] bnd_g_q   [NBND];
   logic [WIDTH-1:0] bnd_p_d   [NBND];
   logic [WIDTH-1:0] bnd_p_q   [NBND];
   logic [WIDTH-1:0] bnd_p0_d  [NBND];
   logic [WIDTH-1:0] bnd_p0_q  [NBND];
   ctl_t             bnd_ctl_d [NBND];
   ctl_t             bnd_ctl_q [NBND];
   logic             bnd_vld_d [NBND];
   logic             bnd_vld_q [NBND];

   logic                 advance_c;
   logic                 out_valid_q;
   logic [WIDTH-1:0]     out_sum_q;
   logic [NBYTE-1:0]     out_cout_q;
   logic [TAG_W-1:0]     out_tag_q;

   logic [WIDTH-1:0]     in_binv_c;
   logic [WIDTH-1:0]     in_mask_c;
   logic [WIDTH-1:0]     in_p_c;

   logic [WIDTH-1:0]     fin_mask_c;
   logic [WIDTH-1:0]     fin_cin_c;
   logic [WIDTH-1:0]     fin_sum_c;
   logic [NBYTE-1:0]     fin_cout_c;
   logic                 unused_fin_p;

   // Whole pipe moves together unless the output is held by the consumer.
   assign advance_c = !out_valid_q | out_ready;
   assign in_ready  = advance_c;

   // Bit-level pg with the element carry-in folded into each element's LSB.
   assign in_binv_c    = in_b ^ {WIDTH{in_sub}};
   assign in_mask_c    = WIDTH'(boundary_mask(sew_e'(in_sew), WIDTH));
   assign in_p_c       = in_a ^ in_binv_c;
   assign bnd_g_d[0]   = (in_a & in_binv_c) | (in_p_c & in_mask_c & {WIDTH{in_sub}});
   assign bnd_p_d[0]   = in_p_c & ~in_mask_c;
   assign bnd_p0_d[0]  = in_p_c;
   assign bnd_ctl_d[0] = '{sew: sew_e'(in_sew), sub: in_sub, tag: in_tag};
   assign bnd_vld_d[0] = in_valid;

   for (genvar l = 0; l < NBND; l++) begin : g_bnd
      if (reg_at(l)) begin : g_reg
         logic [WIDTH-1:0] g_q;
         logic [WIDTH-1:0] p_q;
         logic [WIDTH-1:0] p0_q;
         ctl_t             ctl_q;
         logic             vld_q;

         // Stage valid bit; cleared on reset so in-flight work is dropped.
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= 1'b0;
            end else if (advance_c) begin
               vld_q <= bnd_vld_d[l];
            end
         end

         // Stage payload; meaning is qualified by vld_q so no reset is needed.
         always_ff @(posedge clk) begin
            if (advance_c) begin
               g_q   <= bnd_g_d[l];
               p_q   <= bnd_p_d[l];
               p0_q  <= bnd_p0_d[l];
               ctl_q <= bnd_ctl_d[l];
            end
         end

         assign bnd_g_q[l]   = g_q;
         assign bnd_p_q[l]   = p_q;
         assign bnd_p0_q[l]  = p0_q;
         assign bnd_ctl_q[l] = ctl_q;
         assign bnd_vld_q[l] = vld_q;
      end else begin : g_wire
         assign bnd_g_q[l]   = bnd_g_d[l];
         assign bnd_p_q[l]   = bnd_p_d[l];
         assign bnd_p0_q[l]  = bnd_p0_d[l];
         assign bnd_ctl_q[l] = bnd_ctl_d[l];
         assign bnd_vld_q[l] = bnd_vld_d[l];
      end
   end

   for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
      localparam int unsigned DIST = 32'd1 << k;
      logic [WIDTH-1:0] g_nx;
      logic [WIDTH-1:0] p_nx;

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= DIST) begin : g_cell
            prefix_gp_cell u_cell (
               .g_hi_i (bnd_g_q[k][i]),
               .p_hi_i (bnd_p_q[k][i]),
               .g_lo_i (bnd_g_q[k][i-DIST]),
               .p_lo_i (bnd_p_q[k][i-DIST]),
               .g_o    (g_nx[i]),
               .p_o    (p_nx[i])
            );
         end else begin : g_pass
            assign g_nx[i] = bnd_g_q[k][i];
            assign p_nx[i] = bnd_p_q[k][i];
         end
      end

      assign bnd_g_d[k+1]   = g_nx;
      assign bnd_p_d[k+1]   = p_nx;
      assign bnd_p0_d[k+1]  = bnd_p0_q[k];
      assign bnd_ctl_d[k+1] = bnd_ctl_q[k];
      assign bnd_vld_d[k+1] = bnd_vld_q[k];
   end

   // Group propagate after the last level is not needed for sum or carry-out.
   assign unused_fin_p = ^bnd_p_q[LOG2W];

   // Sum: carry into an element LSB is the carry-in, otherwise the prefix G below.
   always_comb begin
      fin_mask_c = WIDTH'(boundary_mask(bnd_ctl_q[LOG2W].sew, WIDTH));
      fin_cin_c  = (fin_mask_c & {WIDTH{bnd_ctl_q[LOG2W].sub}}) |
                   (~fin_mask_c & {bnd_g_q[LOG2W][WIDTH-2:0], 1'b0});
      fin_sum_c  = bnd_p0_q[LOG2W] ^ fin_cin_c;
   end

   // Carry-out only on the byte lane holding an element MSB.
   for (genvar j = 0; j < NBYTE; j++) begin : g_cout
      if (j == NBYTE - 1) begin : g_top
         assign fin_cout_c[j] = bnd_g_q[LOG2W][8*j+7];
      end else begin : g_mid
         assign fin_cout_c[j] = bnd_g_q[LOG2W][8*j+7] & fin_mask_c[8*j+8];
      end
   end

   // Output register; holds its contents while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cout_q  <= '0;
         out_tag_q   <= '0;
      end else if (advance_c) begin
         out_valid_q <= bnd_vld_q[LOG2W];
         if (bnd_vld_q[LOG2W]) begin
            out_sum_q  <= fin_sum_c;
            out_cout_q <= fin_cout_c;
            out_tag_q  <= bnd_ctl_q[LOG2W].tag;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
   assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_vector_prefix_adder.sv
// Bench for vector_prefix_adder: four instances (PIPE_STAGES 1,2,3,7) share
// stimulus; each has its own scoreboard fed from an arithmetic element model.
module tb_vector_prefix_adder;

   localparam int unsigned W  = 64;
   localparam int unsigned NB = W / 8;
   localparam int unsigned NI = 4;

   typedef struct packed {
      logic [W-1:0]  sum;
      logic [NB-1:0] cout;
      logic [7:0]    tag;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic [1:0]    in_sew = 2'b00;
   logic          in_sub = 1'b0;
   logic [7:0]    in_tag = 8'h00;

   logic          in_ready_w  [NI];
   logic          out_valid_w [NI];
   logic [W-1:0]  out_sum_w   [NI];
   logic [NB-1:0] out_cout_w  [NI];
   logic [7:0]    out_tag_w   [NI];

   int n_tests = 0;
   int n_fail  = 0;
   int sb_depth [NI];

   always #5 clk = ~clk;

   // Reference: plain per-element integer add with explicit carry-in.
   function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] sew,
                                  logic sub, logic [7:0] tag);
      exp_t        e;
      int          eb;
      logic [64:0] m, ae, be, r;
      eb     = 8 << sew;
      e.sum  = '0;
      e.cout = '0;
      e.tag  = tag;
      m      = (65'd1 << eb) - 65'd1;
      for (int off = 0; off < 64; off += eb) begin
         ae = (65'(a) >> off) & m;
         be = (65'(b) >> off) & m;
         if (sub) be = be ^ m;
         r = ae + be + 65'(sub);
         e.sum = e.sum | 64'((r & m) << off);
         e.cout[(off + eb) / 8 - 1] = r[eb];
      end
      return e;
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int unsigned PS = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 3 : 7;
      exp_t sb_q [$];

      vector_prefix_adder #(.WIDTH(W), .PIPE_STAGES(PS)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready_w[gi]),
         .in_a      (in_a),
         .in_b      (in_b),
         .in_sew    (in_sew),
         .in_sub    (in_sub),
         .in_tag    (in_tag),
         .out_valid (out_valid_w[gi]),
         .out_ready (out_ready),
         .out_sum   (out_sum_w[gi]),
         .out_cout  (out_cout_w[gi]),
         .out_tag   (out_tag_w[gi])
      );

      always @(negedge clk) begin
         exp_t e;
         if (rst) begin
            sb_q.delete();
         end else begin
            if (out_valid_w[gi] === 1'b1 && out_ready === 1'b1) begin
               n_tests++;
               if (sb_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_unexpected ps=%0d: got tag %h, expected no output", PS, out_tag_w[gi]);
               end else begin
                  e = sb_q.pop_front();
                  if ({out_sum_w[gi], out_cout_w[gi], out_tag_w[gi]} !== e) begin
                     n_fail++;
                     $display("FAIL sb_result ps=%0d: got sum=%h cout=%h tag=%h, expected sum=%h cout=%h tag=%h",
                              PS, out_sum_w[gi], out_cout_w[gi], out_tag_w[gi], e.sum, e.cout, e.tag);
                  end
               end
            end
            if (in_valid === 1'b1 && in_ready_w[gi] === 1'b1) begin
               sb_q.push_back(model(in_a, in_b, in_sew, in_sub, in_tag));
            end
         end
         sb_depth[gi] = sb_q.size();
      end
   end

   // Drive one transaction and return just after its accept edge.
   task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sew,
                           input logic sub, input logic [7:0] tag);
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = a; in_b = b; in_sew = sew; in_sub = sub; in_tag = tag;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (in_ready_w[1] === 1'b1) break;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count edges from the accept edge until out_valid of instance idx; -1 on timeout.
   task automatic wait_result(input int idx, output int lat);
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (out_valid_w[idx] === 1'b1) begin
            lat = c;
            break;
         end
         @(posedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         n_tests++;
         if ({out_valid_w[i], out_sum_w[i], out_cout_w[i], out_tag_w[i]} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs[%0d]: got v=%b sum=%h cout=%h tag=%h, expected all zero",
                     i, out_valid_w[i], out_sum_w[i], out_cout_w[i], out_tag_w[i]);
         end
      end
      n_tests++;
      if (in_ready_w[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready_w[1]);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] sew, input logic sub, input logic [7:0] tag,
                                input logic [W-1:0] exp_sum, input logic [NB-1:0] exp_cout);
      int lat;
      send_one(a, b, sew, sub, tag);
      wait_result(1, lat);
      n_tests++;
      if (lat !== 2) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d expected 2", name, lat);
      end
      n_tests++;
      if ({out_sum_w[1], out_cout_w[1], out_tag_w[1]} !== {exp_sum, exp_cout, tag}) begin
         n_fail++;
         $display("FAIL %s_value: got sum=%h cout=%h tag=%h, expected sum=%h cout=%h tag=%h",
                  name, out_sum_w[1], out_cout_w[1], out_tag_w[1], exp_sum, exp_cout, tag);
      end
      repeat (10) @(posedge clk);
   endtask

   task automatic test_byte_add();
      test_directed("byte_add", 64'h00000000_000000FF, 64'h1, 2'b00, 1'b0, 8'h11, 64'h0, 8'h01);
   endtask

   task automatic test_full_add();
      test_directed("full_add", 64'h00000000_000000FF, 64'h1, 2'b11, 1'b0, 8'h22, 64'h100, 8'h00);
   endtask

   task automatic test_sub32();
      test_directed("sub32", 64'h5, 64'h7, 2'b10, 1'b1, 8'h33, 64'h00000000_FFFFFFFE, 8'h80);
   endtask

   task automatic test_back_pressure();
      logic [W-1:0] a_l [4];
      logic [W-1:0] b_l [4];
      exp_t         exp_l [4];
      int           idx = 0, got = 0, stall_left = 0;
      bit           seen_first = 1'b0;
      logic [31:0]  tags = '0;
      for (int t = 0; t < 4; t++) begin
         a_l[t]   = {$urandom, $urandom};
         b_l[t]   = {$urandom, $urandom};
         exp_l[t] = model(a_l[t], b_l[t], 2'b01, 1'b0, 8'(t + 1));
      end
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         @(posedge clk); #1;
         out_ready = (stall_left == 0);
         if (idx < 4) begin
            in_valid = 1'b1; in_a = a_l[idx]; in_b = b_l[idx];
            in_sew = 2'b01; in_sub = 1'b0; in_tag = 8'(idx + 1);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (!out_ready) begin
            n_tests++;
            if (in_ready_w[1] !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_in_ready: got %b expected 0", in_ready_w[1]);
            end
            n_tests++;
            if ({out_valid_w[1], out_sum_w[1], out_cout_w[1], out_tag_w[1]} !== {1'b1, exp_l[got]}) begin
               n_fail++;
               $display("FAIL bp_hold: got v=%b tag=%h sum=%h, expected v=1 tag=%h sum=%h",
                        out_valid_w[1], out_tag_w[1], out_sum_w[1], exp_l[got].tag, exp_l[got].sum);
            end
            stall_left--;
         end
         if (in_valid && in_ready_w[1] === 1'b1) idx++;
         if (out_valid_w[1] === 1'b1 && out_ready) begin
            tags = {tags[23:0], out_tag_w[1]};
            got++;
            if (!seen_first) begin
               seen_first = 1'b1;
               stall_left = 3;
            end
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      n_tests++;
      if (got !== 4 || tags !== 32'h01020304) begin
         n_fail++;
         $display("FAIL bp_order: got %0d results tags=%h, expected 4 results tags=01020304", got, tags);
      end
      repeat (12) @(posedge clk);
   endtask

   task automatic test_reset_midflight();
      int   lat;
      exp_t e;
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 64'h1234; in_b = 64'h1; in_sew = 2'b11; in_sub = 1'b0; in_tag = 8'hA1;
      @(posedge clk); #1;
      in_tag = 8'hA2;
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_tests++;
         if ({out_valid_w[0], out_valid_w[1], out_valid_w[2], out_valid_w[3]} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_stale cycle %0d: got valids %b%b%b%b expected 0000", c,
                     out_valid_w[0], out_valid_w[1], out_valid_w[2], out_valid_w[3]);
         end
      end
      e = model(64'hFFFF_0000_FFFF_FFFF, 64'h1, 2'b10, 1'b0, 8'hB7);
      send_one(64'hFFFF_0000_FFFF_FFFF, 64'h1, 2'b10, 1'b0, 8'hB7);
      wait_result(3, lat);
      n_tests++;
      if (lat !== 7) begin
         n_fail++;
         $display("FAIL rst_new_latency: got %0d expected 7", lat);
      end
      n_tests++;
      if ({out_sum_w[3], out_cout_w[3], out_tag_w[3]} !== e) begin
         n_fail++;
         $display("FAIL rst_new_value: got sum=%h cout=%h tag=%h, expected sum=%h cout=%h tag=%h",
                  out_sum_w[3], out_cout_w[3], out_tag_w[3], e.sum, e.cout, e.tag);
      end
      repeat (10) @(posedge clk);
   endtask

   task automatic test_random();
      for (int c = 0; c < 12000; c++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_a      = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
         in_b      = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
         in_sew    = 2'($urandom_range(0, 3));
         in_sub    = 1'($urandom_range(0, 1));
         in_tag    = 8'($urandom);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         n_tests++;
         if (sb_depth[i] != 0) begin
            n_fail++;
            $display("FAIL random_drain[%0d]: got %0d pending results, expected 0", i, sb_depth[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_byte_add();
      test_full_add();
      test_sub32();
      test_back_pressure();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
